// File: rtl/mips_memory_if.sv
// mips_memory_if: bus between the mips core / image loader (master) and
// mips_memory (slave).
//   Core side : instr_addr -> instr_out, data_addr/data_wdata/data_rd_wr -> data_rdata
//   Loader    : load_en, load_valid, load_byte -> load_ready, load_words
//   err       : sticky bounds flag, present only with MIPS_MEM_BOUNDS_CHECK_EN
interface mips_memory_if #(
  parameter int unsigned depth_words = 1024
);
  localparam int unsigned AW = $clog2(depth_words);

  logic [31:0] instr_addr;
  logic [31:0] instr_out;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rd_wr;
  logic [31:0] data_rdata;
  logic        load_en;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic [AW:0] load_words;
`ifdef MIPS_MEM_BOUNDS_CHECK_EN
  logic        err;
`endif

  modport master (
    output instr_addr, data_addr, data_wdata, data_rd_wr,
    output load_en, load_valid, load_byte,
    input  instr_out, data_rdata, load_ready, load_words
`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  instr_addr, data_addr, data_wdata, data_rd_wr,
    input  load_en, load_valid, load_byte,
    output instr_out, data_rdata, load_ready, load_words
`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    , output err
`endif
  );
endinterface

// File: rtl/mips_memory.sv
// mips_memory: word-organised memory answering the mips core's instruction
// and data ports, with a byte-serial image loader.
//   clk, reset : single posedge clock, asynchronous active-high reset
//   bus        : mips_memory_if.slave (core ports, loader ports, load_words)
// Reads are registered (1 cycle), writes commit at the sampling edge,
// read-first on collisions. States: RUN (serve core), LOAD (assemble bytes
// into words), FLUSH (commit a zero-padded partial word).
// Optional macro MIPS_MEM_BOUNDS_CHECK_EN: out-of-range reads return 0,
// out-of-range writes are dropped, and the sticky err output is set.
module mips_memory #(
  parameter logic [31:0] base_addr   = 32'h8002_0000,
  parameter int unsigned depth_words = 1024
) (
  input logic          clk,
  input logic          reset,
  mips_memory_if.slave bus
);

  localparam int unsigned AW      = $clog2(depth_words);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(depth_words);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   instr_out_q, instr_out_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic [AW:0]   load_words_q, load_words_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   asm_q, asm_d;

  logic [31:0]   mem [depth_words];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic [AW-1:0] instr_idx, data_idx;
  logic          instr_ok, data_ok;
  logic          load_ready_c, load_fire;

  // Byte address to word index; low two address bits are dropped.
  function automatic logic [AW-1:0] to_idx(input logic [31:0] addr);
    return AW'((addr - base_addr) >> 2);
  endfunction

  assign instr_idx = to_idx(bus.instr_addr);
  assign data_idx  = to_idx(bus.data_addr);

`ifdef MIPS_MEM_BOUNDS_CHECK_EN
  logic err_q, err_d;

  // 33-bit offset so addresses below base_addr show up as a borrow.
  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base_addr};
    return !off[32] && (off < 33'(4 * depth_words));
  endfunction

  assign instr_ok = in_range(bus.instr_addr);
  assign data_ok  = in_range(bus.data_addr);
  assign bus.err  = err_q;
`else
  assign instr_ok = 1'b1;
  assign data_ok  = 1'b1;
`endif

  assign load_ready_c = (state_q == ST_LOAD) && (load_words_q < DEPTH_W);
  assign load_fire    = bus.load_valid & load_ready_c;

  // Next-state, read data and memory write port.
  always_comb begin
    state_d      = state_q;
    instr_out_d  = 32'h0;
    data_rdata_d = 32'h0;
    load_words_d = load_words_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    mem_we       = 1'b0;
    mem_waddr    = data_idx;
    mem_wdata    = bus.data_wdata;
`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    err_d        = err_q;
`endif

    case (state_q)
      ST_RUN: begin
        instr_out_d  = instr_ok ? mem[instr_idx] : 32'h0;
        data_rdata_d = data_ok  ? mem[data_idx]  : 32'h0;
        if (!bus.data_rd_wr && data_ok) mem_we = 1'b1;
`ifdef MIPS_MEM_BOUNDS_CHECK_EN
        if (!instr_ok || !data_ok) err_d = 1'b1;
`endif
        if (bus.load_en) begin
          state_d      = ST_LOAD;
          cnt_d        = 2'd0;
          load_words_d = '0;
        end
      end

      ST_LOAD: begin
        if (load_fire) begin
          asm_d = {asm_q[15:0], bus.load_byte};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            mem_we       = 1'b1;
            mem_waddr    = load_words_q[AW-1:0];
            mem_wdata    = {asm_q, bus.load_byte};
            load_words_d = load_words_q + (AW+1)'(1);
          end
        end
        // Use the post-accept count so a byte taken on the exit edge is flushed.
        if (!bus.load_en) state_d = (cnt_d != 2'd0) ? ST_FLUSH : ST_RUN;
      end

      ST_FLUSH: begin
        if (load_words_q < DEPTH_W) begin
          mem_we       = 1'b1;
          mem_waddr    = load_words_q[AW-1:0];
          load_words_d = load_words_q + (AW+1)'(1);
          case (cnt_q)
            2'd1:    mem_wdata = {asm_q[7:0],  24'h0};
            2'd2:    mem_wdata = {asm_q[15:0], 16'h0};
            2'd3:    mem_wdata = {asm_q,        8'h0};
            default: mem_wdata = 32'h0;
          endcase
        end
        cnt_d   = 2'd0;
        state_d = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase

    // No stray commits on the edges where reset is held.
    if (reset) mem_we = 1'b0;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      instr_out_q  <= 32'h0;
      data_rdata_q <= 32'h0;
      load_words_q <= '0;
      cnt_q        <= 2'd0;
      asm_q        <= 24'h0;
    end else begin
      state_q      <= state_d;
      instr_out_q  <= instr_out_d;
      data_rdata_q <= data_rdata_d;
      load_words_q <= load_words_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
    end
  end

`ifdef MIPS_MEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.instr_out  = instr_out_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.load_ready = load_ready_c;
  assign bus.load_words = load_words_q;

endmodule

// File: tb/tb_mips_memory.sv
// Bench for mips_memory: directed loader/collision/reset sequences, a vector
// table of core accesses, and random core traffic against an array model.
module tb_mips_memory;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h8002_0000;

  logic clk;
  logic reset;

  mips_memory_if #(.depth_words(DEPTH)) bus ();

  mips_memory #(.base_addr(BASE), .depth_words(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  logic [31:0] model [DEPTH];

  typedef struct {
    int          ii;
    int          di;
    bit          wr;
    logic [31:0] wd;
    logic [31:0] exp_i;
    bit          chk_d;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic [31:0] ia, input logic [31:0] da,
                            input bit wr, input logic [31:0] wd);
    bus.instr_addr = ia;
    bus.data_addr  = da;
    bus.data_rd_wr = !wr;
    bus.data_wdata = wd;
  endtask

  function automatic logic [31:0] waddr(input int idx);
    return BASE + 32'(idx * 4);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_byte  = 8'h0;
    drive_core(BASE, BASE, 1'b0, 32'h0);

    // Reset values
    #2 reset = 1'b1;
    #1;
    check("rst_instr_out", bus.instr_out, 32'h0);
    check("rst_data_rdata", bus.data_rdata, 32'h0);
    check("rst_load_words", 32'(bus.load_words), 32'h0);
    check("rst_load_ready", 32'(bus.load_ready), 32'h0);
`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    check("rst_err", 32'(bus.err), 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Load: byte offered on the RUN->LOAD edge must be ignored
    bus.load_en = 1'b1; bus.load_valid = 1'b1; bus.load_byte = 8'h99;
    cyc();
    check("load_ready_in_load", 32'(bus.load_ready), 32'h1);
    check("load_words_cleared", 32'(bus.load_words), 32'h0);
    bus.load_byte = 8'h24; cyc();
    bus.load_byte = 8'h08; cyc();
    bus.load_byte = 8'h00; cyc();
    bus.load_byte = 8'h05; cyc();
    check("load_words_after_4", 32'(bus.load_words), 32'h1);
    bus.load_byte = 8'hAB; cyc();
    bus.load_valid = 1'b0; cyc();
    bus.load_en = 1'b0;    cyc();   // -> FLUSH
    cyc();                          // FLUSH commits, -> RUN
    check("load_words_flush", 32'(bus.load_words), 32'h2);
    check("load_ready_run", 32'(bus.load_ready), 32'h0);
    drive_core(waddr(1), waddr(0), 1'b0, 32'h0);
    cyc();
    check("flush_word", bus.instr_out, 32'hAB00_0000);
    check("first_word", bus.data_rdata, 32'h2408_0005);

    // Vector table of core accesses (read-first on collisions)
    vecs[0] = '{1, 2, 1'b1, 32'hDEAD_BEEF, 32'hAB00_0000, 1'b0, 32'h0};
    vecs[1] = '{0, 2, 1'b0, 32'h0,         32'h2408_0005, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{2, 3, 1'b1, 32'h1,         32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[3] = '{3, 3, 1'b1, 32'h2,         32'h1,         1'b1, 32'h1};
    vecs[4] = '{3, 0, 1'b0, 32'h0,         32'h2,         1'b1, 32'h2408_0005};
    vecs[5] = '{0, 0, 1'b1, 32'h1234_5678, 32'h2408_0005, 1'b1, 32'h2408_0005};
    vecs[6] = '{1, 0, 1'b0, 32'h0,         32'hAB00_0000, 1'b1, 32'h1234_5678};
    for (int v = 0; v < 7; v++) begin
      drive_core(waddr(vecs[v].ii), waddr(vecs[v].di), vecs[v].wr, vecs[v].wd);
      cyc();
      check($sformatf("vec%0d_instr", v), bus.instr_out, vecs[v].exp_i);
      if (vecs[v].chk_d) check($sformatf("vec%0d_data", v), bus.data_rdata, vecs[v].exp_d);
    end
    model[0] = 32'h1234_5678; model[1] = 32'hAB00_0000;
    model[2] = 32'hDEAD_BEEF; model[3] = 32'h2;

    // Random core traffic against the array model
    for (int n = 0; n < 200; n++) begin
      int ii, di, ka, kd;
      bit wr;
      logic [31:0] wd, ei, ed;
      ii = int'($urandom_range(0, DEPTH - 1));
      di = int'($urandom_range(0, DEPTH - 1));
`ifdef MIPS_MEM_BOUNDS_CHECK_EN
      ka = 0; kd = 0;
`else
      ka = int'($urandom_range(0, 3));
      kd = int'($urandom_range(0, 3));
`endif
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      ei = model[ii];
      ed = model[di];
      if (wr) model[di] = wd;
      drive_core(waddr(ii + ka * DEPTH) + 32'($urandom_range(0, 3)),
                 waddr(di + kd * DEPTH) + 32'($urandom_range(0, 3)), wr, wd);
      cyc();
      check("rand_instr", bus.instr_out, ei);
      check("rand_data", bus.data_rdata, ed);
    end
    drive_core(BASE, BASE, 1'b0, 32'h0);

    // Overflow: 20 bytes into a 4-word memory
    bus.load_en = 1'b1; cyc();
    bus.load_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.load_byte = 8'(i + 1);
      cyc();
      check($sformatf("ovf_ready_%0d", i + 1), 32'(bus.load_ready), (i < 15) ? 32'h1 : 32'h0);
    end
    check("ovf_load_words", 32'(bus.load_words), 32'h4);
    bus.load_valid = 1'b0; bus.load_en = 1'b0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      model[k] = {8'(4*k + 1), 8'(4*k + 2), 8'(4*k + 3), 8'(4*k + 4)};
    end
    for (int k = 0; k < 4; k++) begin
      drive_core(waddr(k), waddr(3 - k), 1'b0, 32'h0);
      cyc();
      check($sformatf("ovf_instr_w%0d", k), bus.instr_out, model[k]);
      check($sformatf("ovf_data_w%0d", 3 - k), bus.data_rdata, model[3 - k]);
    end

    // Reset in the middle of the second word of a load
    bus.load_en = 1'b1; cyc();
    bus.load_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.load_byte = 8'(8'hA1 + i);
      cyc();
    end
    bus.load_valid = 1'b0;
    check("mid_load_words", 32'(bus.load_words), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_load_words", 32'(bus.load_words), 32'h0);
    check("mid_rst_load_ready", 32'(bus.load_ready), 32'h0);
    bus.load_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model[0] = 32'hA1A2_A3A4;
    drive_core(waddr(0), waddr(1), 1'b0, 32'h0);
    cyc();
    check("mid_rst_kept_word", bus.instr_out, model[0]);
    check("mid_rst_untouched", bus.data_rdata, model[1]);

`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    check("err_clear_before", 32'(bus.err), 32'h0);
    drive_core(waddr(0), BASE - 32'd4, 1'b1, 32'hFFFF_FFFF);
    cyc();
    check("oob_instr_ok", bus.instr_out, model[0]);
    check("oob_read_zero", bus.data_rdata, 32'h0);
    check("err_set", 32'(bus.err), 32'h1);
    for (int k = 0; k < 4; k++) begin
      drive_core(waddr(k), waddr(k), 1'b0, 32'h0);
      cyc();
      check($sformatf("oob_unchanged_w%0d", k), bus.data_rdata, model[k]);
      check("err_sticky", 32'(bus.err), 32'h1);
    end
`else
    drive_core(waddr(0), waddr(DEPTH), 1'b1, 32'hCAFE_F00D);
    cyc();
    check("alias_instr_old", bus.instr_out, model[0]);
    model[0] = 32'hCAFE_F00D;
    drive_core(waddr(1), waddr(0), 1'b0, 32'h0);
    cyc();
    check("alias_word0", bus.data_rdata, model[0]);
    check("alias_word1", bus.instr_out, model[1]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_memory.md
# mips_memory

Word-organised memory that serves as the responder for the `mips` core's instruction and data memory ports. It returns `instr_in` and `data_in` to the core and accepts stores when `data_rd_wr` is 0. A byte-serial load port fills the memory with a program image while the core is held in reset. Reads are registered, and the block sits beside `mips` at the top level, on the same clock.

## Interface
Parameters:
- `base_addr`, default 32'h8002_0000: byte address of word 0. Must be word aligned.
- `depth_words`, default 1024: number of 32-bit words. Must be a power of 2, at least 4.
- `AW`, localparam: log2(`depth_words`).

Ports:
- `clk` input, 1 bit: single clock. Everything is posedge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `instr_addr` input, 32 bits: instruction fetch byte address from the core.
- `instr_out` output, 32 bits: fetched word. Connects to the core's `instr_in`.
- `data_addr` input, 32 bits: data byte address from the core.
- `data_wdata` input, 32 bits: store data. Connects to the core's `data_out`.
- `data_rd_wr` input, 1 bit: 1 means read, 0 means write.
- `data_rdata` output, 32 bits: load data. Connects to the core's `data_in`.
- `load_en` input, 1 bit: level signal; high requests load mode.
- `load_valid` input, 1 bit: `load_byte` is valid.
- `load_byte` input, 8 bits: image byte, big-endian within each word.
- `load_ready` output, 1 bit: a byte is accepted on `load_valid & load_ready`.
- `load_words` output, AW+1 bits: number of words committed during the current or last load.
- `err` output, 1 bit: sticky bounds-violation flag. Only exists with the configuration macro (see Configuration).

## Operation
Address mapping:
- `idx = (addr - base_addr) >> 2`, truncated to AW bits.
- `addr[1:0]` is ignored.

States: RUN, LOAD, FLUSH.
- **RUN**
  - Serves the core.
  - Each posedge registers `instr_out <= mem[idx(instr_addr)]` and `data_rdata <= mem[idx(data_addr)]`.
  - If `data_rd_wr == 0`, writes `mem[idx(data_addr)] <= data_wdata` on the same edge.
  - If `load_en` is 1, goes to LOAD and clears the byte pointer and `load_words`.
- **LOAD**
  - Core ports are ignored: no writes occur, and `instr_out` and `data_rdata` are held at 0.
  - `load_ready = (load_words < depth_words)`.
  - Each accepted byte shifts into the assembly register (`asm <= {asm[23:0], load_byte}`) and increments the 2-bit byte counter.
  - On the 4th byte, the full word `{asm[23:0], load_byte}` is written to `mem[load_words]`, `load_words` increments and the byte counter clears.
  - When the memory is full, `load_ready` is 0 and further bytes are ignored.
  - If `load_en` is 0: go to FLUSH when the byte counter is nonzero, otherwise go to RUN.
- **FLUSH**
  - Lasts one cycle.
  - Writes the partial word left-justified and zero-padded: a counter value of k bytes gives `asm[8k-1:0] << (32-8k)`.
  - The write only occurs if `load_words < depth_words`; `load_words` increments in that case.
  - Then goes to RUN.

Boundary and collision rules:
- `load_en` and `load_valid` sampled on the same edge as the RUN→LOAD transition: the byte is not accepted, because `load_ready` was 0 in RUN.
- Data write and instruction read to the same word on the same edge: `instr_out` returns the old word (read-first).
- Data write and data read to the same word: `data_rdata` returns the old word.

## Timing
Reset:
- On `reset`: state goes to RUN; `instr_out`, `data_rdata`, `load_words`, the byte counter and `asm` go to 0; `load_ready` goes to 0; `err` goes to 0.
- Memory contents are not reset.
- Reset during LOAD abandons the partial word. Words already committed are kept.

Latency:
- Reads: 1 cycle. The address is sampled at edge N, and data is valid after edge N until edge N+1. This matches the core, which holds each address for its whole multi-cycle step.
- Writes: commit at the sampling edge. A read of the same word at the next edge sees the new value.
- Load throughput: 1 byte per cycle. The word write coincides with the edge that accepts the 4th byte.
- `load_ready` is combinational from state and `load_words`.

## Configuration
Macro `MIPS_MEM_BOUNDS_CHECK_EN`.
- **Defined:** an access is out of range when `addr < base_addr` or `addr >= base_addr + 4*depth_words`, checked per port.
  - An out-of-range read registers 0.
  - An out-of-range write is dropped.
  - Either sets `err`, which stays 1 until reset.
- **Undefined:** no range check; addresses alias modulo the memory size via the truncated `idx`. The `err` port is absent.

## Test plan
1. Load and read back: after reset, `load_en` = 1, stream bytes 8'h24,8'h08,8'h00,8'h05 then 8'hAB, drop `load_en` → `mem[0]` = 32'h2408_0005, FLUSH writes `mem[1]` = 32'hAB00_0000, `load_words` = 2; in RUN, `instr_addr` = `base_addr`+4 → `instr_out` = 32'hAB00_0000 one cycle later.
2. Store then load: `data_addr` = `base_addr`+8, `data_wdata` = 32'hDEAD_BEEF, `data_rd_wr` = 0 for one edge, then `data_rd_wr` = 1 → `data_rdata` = 32'hDEAD_BEEF after the next edge.
3. Read-first collision: `mem[3]` = 32'h1; on the same edge, write 32'h2 via the data port and fetch word 3 via the instruction port → `instr_out` = 32'h1 on that edge, 32'h2 on the following edge.
4. Load overflow with `depth_words` = 4: stream 20 bytes → `load_ready` falls after byte 16, `load_words` = 4, `mem` holds only the first 16 bytes.
5. Reset mid-load: 2 bytes accepted, then `reset` asserted → `load_words` = 0, state RUN, `mem[0]` unchanged from its pre-load value.
6. Bounds, with `MIPS_MEM_BOUNDS_CHECK_EN` defined: write to `base_addr` - 4 → no memory changes, `err` = 1 and it stays 1. With the macro undefined, a write to `base_addr`+4*`depth_words` aliases to `mem[0]`.
